// File: rtl/gshare_pht.sv
// gshare pattern history table: PC/history-indexed 2-bit counters with a
// Decode-stage training path, misprediction flag and saturating statistics.
module gshare_pht #(
    parameter int unsigned HIST_BITS  = 3,
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Fpc,
    input  logic [HIST_BITS-1:0] globalhistoryin,
    input  logic                 Dstall,
    input  logic                 FlushD,
    input  logic [1:0]           Dbranch,
    input  logic                 branchcircuitout,
    output logic                 predicttaken,
    output logic                 Dpredicttaken,
    output logic                 Dmispredict,
    output logic [CNT_BITS-1:0]  branchcount,
    output logic [CNT_BITS-1:0]  mispredictcount
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;

    logic [1:0]            tbl [DEPTH];
    logic [INDEX_BITS-1:0] hist_ext;
    logic [INDEX_BITS-1:0] fidx;
    logic [INDEX_BITS-1:0] didx;
    logic                  dvalid;
    logic                  dcond;
    logic                  train;
    logic [1:0]            dentry;
    logic                  fpc_unused;

    // PC bits outside the index field and the branch-type LSB carry no meaning here
    assign fpc_unused = ^{Fpc[31:INDEX_BITS+2], Fpc[1:0], Dbranch[0]};

    // Fetch-side index and prediction; reads never see a same-cycle update
    always_comb begin
        hist_ext     = INDEX_BITS'(globalhistoryin);
        fidx         = Fpc[INDEX_BITS+1:2] ^ hist_ext;
        predicttaken = tbl[fidx][1];
    end

    // Decode-side resolution: mispredict flag and single-shot training enable
    always_comb begin
        dcond       = dvalid && !Dbranch[1];
        Dmispredict = dcond && (Dpredicttaken != branchcircuitout);
        train       = dcond && !Dstall;
        dentry      = tbl[didx];
    end

    // D-stage register: flush beats stall, stall holds the lookup for training
    always_ff @(posedge clk) begin
        if (reset) begin
            didx          <= '0;
            dvalid        <= 1'b0;
            Dpredicttaken <= 1'b0;
        end else if (FlushD) begin
            dvalid        <= 1'b0;
            Dpredicttaken <= 1'b0;
        end else if (!Dstall) begin
            didx          <= fidx;
            dvalid        <= 1'b1;
            Dpredicttaken <= predicttaken;
        end
    end

    // Counter table: reset to weak-not-taken, saturating train on the stored index
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= 2'b01;
            end
        end else if (train) begin
            if (branchcircuitout) begin
                if (dentry != 2'b11) tbl[didx] <= dentry + 2'b01;
            end else begin
                if (dentry != 2'b00) tbl[didx] <= dentry - 2'b01;
            end
        end
    end

    // Performance counters: count on the training edge only, stick at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            branchcount     <= '0;
            mispredictcount <= '0;
        end else if (train) begin
            if (branchcount != '1) branchcount <= branchcount + 1'b1;
            if (Dmispredict && (mispredictcount != '1)) mispredictcount <= mispredictcount + 1'b1;
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed self-checking bench for gshare_pht with hand-computed expectations.
module tb_gshare_pht;

    logic        clk;
    logic        reset;
    logic [31:0] Fpc;
    logic [2:0]  globalhistoryin;
    logic        Dstall;
    logic        FlushD;
    logic [1:0]  Dbranch;
    logic        branchcircuitout;
    logic        predicttaken;
    logic        Dpredicttaken;
    logic        Dmispredict;
    logic [15:0] branchcount;
    logic [15:0] mispredictcount;

    int unsigned n_checks;
    int unsigned n_pass;

    gshare_pht #(
        .HIST_BITS  (3),
        .INDEX_BITS (3),
        .CNT_BITS   (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Fpc              (Fpc),
        .globalhistoryin  (globalhistoryin),
        .Dstall           (Dstall),
        .FlushD           (FlushD),
        .Dbranch          (Dbranch),
        .branchcircuitout (branchcircuitout),
        .predicttaken     (predicttaken),
        .Dpredicttaken    (Dpredicttaken),
        .Dmispredict      (Dmispredict),
        .branchcount      (branchcount),
        .mispredictcount  (mispredictcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One branch: load into D (no training), then resolve with hist possibly shifted
    task automatic run_branch(input string tag, input logic [31:0] pc, input logic [2:0] hf,
                              input logic [2:0] hr, input logic outcome,
                              input logic exp_misp, input logic exp_pred);
        Fpc = pc; globalhistoryin = hf; Dbranch = 2'b10;
        step();
        globalhistoryin = hr; Dbranch = 2'b00; branchcircuitout = outcome;
        #1;
        check({tag, "_misp"}, 32'(Dmispredict), 32'(exp_misp));
        step();
        Dbranch = 2'b10; globalhistoryin = hf;
        #1;
        check({tag, "_pred"}, 32'(predicttaken), 32'(exp_pred));
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; Fpc = 32'h40; globalhistoryin = 3'b000;
        Dstall = 1'b0; FlushD = 1'b0; Dbranch = 2'b10; branchcircuitout = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_pred",  32'(predicttaken), 0);
        check("rst_dpred", 32'(Dpredicttaken), 0);
        check("rst_misp",  32'(Dmispredict), 0);
        check("rst_bc",    32'(branchcount), 0);
        check("rst_mc",    32'(mispredictcount), 0);

        // Train index 0: 01->10->11->11, then NT ->10, NT ->01, T ->10
        run_branch("t1",  32'h40, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);
        run_branch("t2",  32'h40, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        run_branch("t3",  32'h40, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        run_branch("nt1", 32'h40, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);
        run_branch("nt2", 32'h40, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        run_branch("t4",  32'h40, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);
        check("train_bc", 32'(branchcount), 6);
        check("train_mc", 32'(mispredictcount), 4);

        // Aliasing 0x44^001 -> index 0; history shifts before resolve must not retarget
        run_branch("alias", 32'h44, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1);
        Fpc = 32'h44; globalhistoryin = 3'b000;
        #1;
        check("alias_idx1", 32'(predicttaken), 0);
        check("alias_bc", 32'(branchcount), 7);
        check("alias_mc", 32'(mispredictcount), 4);

        // Fresh table, stalled conditional branch trains once on release
        reset = 1'b1;
        step();
        reset = 1'b0; Fpc = 32'h40; globalhistoryin = 3'b000; Dbranch = 2'b10;
        step();
        Dbranch = 2'b01; branchcircuitout = 1'b1; Dstall = 1'b1;
        #1;
        check("stall_misp0", 32'(Dmispredict), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_misp", 32'(Dmispredict), 1);
            check("stall_bc", 32'(branchcount), 0);
        end
        Dstall = 1'b0;
        step();
        check("rel_bc", 32'(branchcount), 1);
        check("rel_mc", 32'(mispredictcount), 1);
        check("rel_pred", 32'(predicttaken), 1);
        check("rel_nobypass", 32'(Dpredicttaken), 0);
        Dbranch = 2'b10;
        step();
        check("rel_once_bc", 32'(branchcount), 1);
        check("rel_entry10", 32'(Dpredicttaken), 1);

        // Flush while entering Decode, then non-conditional branch type
        FlushD = 1'b1;
        step();
        FlushD = 1'b0; Dbranch = 2'b00; branchcircuitout = 1'b1;
        #1;
        check("flush_dpred", 32'(Dpredicttaken), 0);
        check("flush_misp", 32'(Dmispredict), 0);
        branchcircuitout = 1'b0;
        step();
        check("flush_bc", 32'(branchcount), 1);
        check("flush_mc", 32'(mispredictcount), 1);
        check("flush_pred", 32'(predicttaken), 1);
        Dbranch = 2'b10;
        #1;
        check("nc_misp", 32'(Dmispredict), 0);
        step();
        check("nc_bc", 32'(branchcount), 1);
        check("nc_pred", 32'(predicttaken), 1);

        // Saturation: every fire mispredicted
        Dbranch = 2'b00;
        for (int i = 0; i < 65540; i++) begin
            branchcircuitout = ~Dpredicttaken;
            step();
            if (i == 99) begin
                check("mid_bc", 32'(branchcount), 101);
                check("mid_mc", 32'(mispredictcount), 101);
            end
        end
        check("sat_bc", 32'(branchcount), 32'hFFFF);
        check("sat_mc", 32'(mispredictcount), 32'hFFFF);

        // Reset mid-stall with flush and a pending mispredicted branch
        Dstall = 1'b1; FlushD = 1'b1; branchcircuitout = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; FlushD = 1'b0; Dstall = 1'b0; Dbranch = 2'b10;
        #1;
        check("rst2_bc", 32'(branchcount), 0);
        check("rst2_mc", 32'(mispredictcount), 0);
        check("rst2_dpred", 32'(Dpredicttaken), 0);
        check("rst2_misp", 32'(Dmispredict), 0);
        globalhistoryin = 3'b000;
        for (int i = 0; i < 8; i++) begin
            Fpc = 32'h40 + 32'(i * 4);
            #1;
            check("rst2_entry", 32'(predicttaken), 0);
        end
        run_branch("rst2_t", 32'h40, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
